// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg
//   Shared types and default sizes for the multi-requester APB arbiter.
//   apb_state_e : bus-phase FSM encoding (IDLE, SETUP, ACCESS)
//   *_DEF       : default parameter values used by apb_arbiter
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int N_REQ_DEF       = 2;
   localparam int AW_DEF          = 32;
   localparam int DW_DEF          = 32;
   localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter
//   Purely combinational round-robin pick. The search starts one past the
//   previous winner and wraps, so the last requester served has lowest
//   priority next time.
//   req_i        : pending request vector
//   last_grant_i : index of the previous winner
//   grant_o      : one-hot winner (all zero when nothing pending)
//   idx_o        : binary index of the winner
//   any_o        : at least one request pending
module apb_rr_arbiter
#(
   parameter int N_REQ = 2,
   parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    last_grant_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IW-1:0]    idx_o,
   output logic             any_o
);

   always_comb begin
      int cand;
      cand    = 0;
      idx_o   = '0;
      any_o   = 1'b0;
      // k = 1 is the highest-priority slot, k = N_REQ is the previous winner
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(last_grant_i) + k) % N_REQ;
         if (!any_o && req_i[cand]) begin
            any_o = 1'b1;
            idx_o = IW'(cand);
         end
      end
      grant_o = {{(N_REQ-1){1'b0}}, any_o} << idx_o;
   end

endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter
//   Shares one APB master port among N_REQ requesters. Round-robin picks a
//   single pending request in IDLE, runs SETUP then ACCESS, and returns a
//   registered one-cycle completion pulse to the requester that was served.
//   Optional macro APB_ARB_TIMEOUT_EN: abort an ACCESS phase that waits
//   TIMEOUT_CYC cycles without PREADY, completing with rsp_err = 1.
//   Ports:
//     PCLK, PRESETn                : clock, async active-low reset
//     req_valid/write/addr/wdata   : per-requester request (packed buses)
//     req_ready                    : one-hot accept, combinational in IDLE
//     rsp_valid, rsp_rdata, rsp_err: registered completion
//     PSEL..PWDATA, PRDATA, PREADY, PSLVERR : APB master side
module apb_arbiter
   import apb_arb_pkg::*;
#(
   parameter int N_REQ       = N_REQ_DEF,
   parameter int AW          = AW_DEF,
   parameter int DW          = DW_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ-1:0]    req_write,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ*DW-1:0] req_wdata,
   output logic [N_REQ-1:0]    req_ready,
   output logic [N_REQ-1:0]    rsp_valid,
   output logic [DW-1:0]       rsp_rdata,
   output logic                rsp_err,
   output logic                PSEL,
   output logic                PENABLE,
   output logic                PWRITE,
   output logic [AW-1:0]       PADDR,
   output logic [DW-1:0]       PWDATA,
   input  logic [DW-1:0]       PRDATA,
   input  logic                PREADY,
   input  logic                PSLVERR
);

   localparam int IW = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("apb_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
   end

   apb_state_e       state_q, state_d;
   logic [IW-1:0]    last_q, idx_q;
   logic [AW-1:0]    addr_q;
   logic [DW-1:0]    wdata_q, rdata_q;
   logic             write_q, err_q;
   logic [N_REQ-1:0] rsp_valid_q;

   logic [N_REQ-1:0] win_gnt;
   logic [IW-1:0]    win_idx;
   logic             win_any;
   logic             to_hit;   // ACCESS abandoned by the wait limit
   logic             done;     // transfer finishes this cycle

   apb_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
      .req_i        (req_valid),
      .last_grant_i (last_q),
      .grant_o      (win_gnt),
      .idx_o        (win_idx),
      .any_o        (win_any)
   );

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt_q;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt_q <= '0;
      end else if (state_q == SETUP) begin
         cnt_q <= '0;
      end else if (state_q == ACCESS && !PREADY) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // cnt_q counts earlier wait cycles, so this fires on the TIMEOUT_CYC-th
   assign to_hit = (state_q == ACCESS) && !PREADY && (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
   assign to_hit = 1'b0;
`endif

   assign done = (state_q == ACCESS) && (PREADY || to_hit);

   always_comb begin
      state_d   = state_q;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            // gated by reset so a held request is never acknowledged while
            // the block is being cleared
            if (PRESETn) req_ready = win_gnt;
            if (win_any) state_d = SETUP;
         end
         SETUP: begin
            PSEL    = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         last_q      <= IW'(N_REQ - 1);
         idx_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         rsp_valid_q <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= '0;
         if (state_q == IDLE && win_any) begin
            idx_q   <= win_idx;
            last_q  <= win_idx;
            addr_q  <= req_addr[win_idx*AW +: AW];
            wdata_q <= req_wdata[win_idx*DW +: DW];
            write_q <= req_write[win_idx];
         end
         if (done) begin
            rsp_valid_q <= {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;
            rdata_q     <= (PREADY && !write_q) ? PRDATA : '0;
            err_q       <= PREADY ? PSLVERR : 1'b1;
         end
      end
   end

   // bus fields come straight from the latch, so they hold through IDLE
   assign PADDR     = addr_q;
   assign PWDATA    = wdata_q;
   assign PWRITE    = write_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter
//   Transaction-level checks of apb_arbiter with N_REQ = 4. Requests live in a
//   per-requester table; the expected winner follows the rotation rule, and
//   each transfer is walked phase by phase (accept, SETUP, ACCESS..., response)
//   against the documented latencies. Inputs change and outputs are sampled on
//   the falling clock edge.
module tb_apb_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;
`ifdef APB_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic [N-1:0]  req_valid, req_write, req_ready, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0] rsp_rdata, PWDATA, PRDATA;
   logic          rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [AW-1:0] PADDR;

   int n_tests = 0;
   int n_fail  = 0;

   // request table and reference state
   bit            pending [N];
   bit            m_write [N];
   logic [AW-1:0] m_addr  [N];
   logic [DW-1:0] m_wdata [N];
   int            m_last;
   logic [DW-1:0] last_rd;
   logic          last_err;

   apb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      if (i >= 0 && i < N) v[i] = 1'b1;
      return v;
   endfunction

   // first pending requester scanning upward from the previous winner + 1
   function automatic int exp_winner();
      for (int k = 1; k <= N; k++)
         if (pending[(m_last + k) % N]) return (m_last + k) % N;
      return -1;
   endfunction

   function automatic bit any_pending();
      for (int i = 0; i < N; i++) if (pending[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic post(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pending[i] = 1'b1;
      m_write[i] = wr;
      m_addr[i]  = a;
      m_wdata[i] = d;
   endtask

   task automatic post_rand(input int i);
      post(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]             = pending[i];
         req_write[i]             = m_write[i];
         req_addr[i*AW +: AW]     = m_addr[i];
         req_wdata[i*DW +: DW]    = m_wdata[i];
      end
   endtask

   // Entered just after a falling edge with requests driven and the DUT in
   // IDLE; returns at the response cycle (also the next arbitration cycle).
   task automatic do_transfer(input int waits, input logic [DW-1:0] prd, input logic perr,
                              output int served, output logic [N-1:0] got_rdy);
      int            w, n_acc;
      bit            tmo, ewr;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed, erd;
      logic          eerr;
      w      = exp_winner();
      served = w;
      #1;
      got_rdy = req_ready;
      n_tests++;
      if (w < 0 || req_ready !== onehot(w)) begin
         n_fail++;
         $display("FAIL accept: req_ready=%b expected winner %0d", req_ready, w);
      end
      if (w < 0) begin
         $display("FAIL bench_state: transfer started with no pending request");
         $fatal(1, "no pending request");
      end
      ea = m_addr[w]; ed = m_wdata[w]; ewr = m_write[w];
      pending[w] = 1'b0;
      m_last = w;
      tmo   = TO_EN && (waits >= TO);
      n_acc = tmo ? TO : waits + 1;

      // SETUP: slave inputs are don't-care here
      @(negedge PCLK);
      drive_reqs();
      PREADY = 1'($urandom_range(0, 1)); PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, ewr, ea, ed} ||
          req_ready !== '0 || rsp_valid !== '0) begin
         n_fail++;
         $display("FAIL setup: sel=%b en=%b wr=%b addr=%h wdata=%h rdy=%b rsp=%b want wr=%b addr=%h wdata=%h",
                  PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, ewr, ea, ed);
      end

      for (int c = 0; c < n_acc; c++) begin
         @(negedge PCLK);
         drive_reqs();
         PREADY  = (c == waits);
         PRDATA  = (c == waits) ? prd : $urandom;
         PSLVERR = (c == waits) ? perr : 1'($urandom_range(0, 1));
         #1;
         n_tests++;
         if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b1, ewr, ea, ed} ||
             req_ready !== '0 || rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL access%0d: sel=%b en=%b wr=%b addr=%h wdata=%h rdy=%b rsp=%b want addr=%h wdata=%h",
                     c, PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, ea, ed);
         end
      end

      @(negedge PCLK);
      drive_reqs();
      PREADY = 1'($urandom_range(0, 1)); PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
      erd  = (tmo || ewr) ? '0 : prd;
      eerr = tmo ? 1'b1 : perr;
      last_rd  = erd;
      last_err = eerr;
      #1;
      n_tests++;
      if (rsp_valid !== onehot(w) || rsp_rdata !== erd || rsp_err !== eerr ||
          PSEL !== 1'b0 || PENABLE !== 1'b0) begin
         n_fail++;
         $display("FAIL response: rsp_valid=%b rdata=%h err=%b sel=%b want rsp_valid=%b rdata=%h err=%b",
                  rsp_valid, rsp_rdata, rsp_err, PSEL, onehot(w), erd, eerr);
      end
   endtask

   task automatic idle_cycle();
      @(negedge PCLK);
      drive_reqs();
      PREADY = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (PSEL !== 1'b0 || PENABLE !== 1'b0 || req_ready !== '0 || rsp_valid !== '0 ||
          rsp_rdata !== last_rd || rsp_err !== last_err) begin
         n_fail++;
         $display("FAIL idle: sel=%b en=%b rdy=%b rsp=%b rdata=%h err=%b want held rdata=%h err=%b",
                  PSEL, PENABLE, req_ready, rsp_valid, rsp_rdata, rsp_err, last_rd, last_err);
      end
   endtask

   task automatic test_reset();
      @(negedge PCLK);
      #1;
      n_tests++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
         n_fail++;
         $display("FAIL reset: sel=%b en=%b wr=%b addr=%h wdata=%h rdy=%b rsp=%b rdata=%h err=%b want all 0",
                  PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      PRESETn  = 1'b1;
      m_last   = N - 1;
      last_rd  = '0;
      last_err = 1'b0;
      idle_cycle();
   endtask

   task automatic test_single_read();
      int s; logic [N-1:0] r;
      post(0, 1'b0, 32'h0000_0010, $urandom);
      drive_reqs();
      do_transfer(0, 32'hDEAD_BEEF, 1'b0, s, r);
   endtask

   task automatic test_write_wait();
      int s; logic [N-1:0] r;
      post(1, 1'b1, 32'h0000_0024, 32'h5A5A_5A5A);
      drive_reqs();
      do_transfer(3, $urandom, 1'b0, s, r);
   endtask

   task automatic test_slverr();
      int s; logic [N-1:0] r;
      post(2, 1'b0, $urandom, $urandom);
      drive_reqs();
      do_transfer(0, $urandom, 1'b1, s, r);
      post(3, 1'b0, $urandom, $urandom);
      drive_reqs();
      do_transfer(1, $urandom, 1'b0, s, r);
   endtask

   task automatic test_rotation();
      int s; logic [N-1:0] r;
      for (int i = 0; i < N; i++) post_rand(i);
      drive_reqs();
      for (int k = 0; k <= N; k++) begin
         do_transfer($urandom_range(0, 2), $urandom, 1'($urandom_range(0, 1)), s, r);
         n_tests++;
         if (r !== onehot(k % N)) begin
            n_fail++;
            $display("FAIL rotation%0d: req_ready=%b want %b", k, r, onehot(k % N));
         end
         post_rand(s);
         drive_reqs();
      end
      // withdraw everything unserved; nothing may be accepted
      for (int i = 0; i < N; i++) pending[i] = 1'b0;
      drive_reqs();
      #1;
      n_tests++;
      if (req_ready !== '0) begin
         n_fail++;
         $display("FAIL withdraw: req_ready=%b want 0", req_ready);
      end
      idle_cycle();
      idle_cycle();
   endtask

   task automatic test_long_wait();
      int s; logic [N-1:0] r;
      post(1, 1'b0, $urandom, $urandom);
      drive_reqs();
      do_transfer(20, $urandom, 1'b0, s, r);
      idle_cycle();
   endtask

   task automatic test_reset_mid();
      int s; logic [N-1:0] r;
      post(2, 1'b0, 32'h0000_0040, $urandom);
      drive_reqs();
      #1;
      n_tests++;
      if (req_ready !== onehot(2)) begin
         n_fail++;
         $display("FAIL reset_mid_accept: req_ready=%b want %b", req_ready, onehot(2));
      end
      pending[2] = 1'b0;
      m_last = 2;
      @(negedge PCLK);
      drive_reqs();
      PREADY = 1'b0;
      @(negedge PCLK);
      PREADY = 1'b0;
      #1;
      n_tests++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_access: sel=%b en=%b want 1 1", PSEL, PENABLE);
      end
      post(0, 1'b0, $urandom, $urandom);
      post(1, 1'b1, $urandom, $urandom);
      @(negedge PCLK);
      drive_reqs();
      PRESETn = 1'b0;
      #1;
      n_tests++;
      if (PSEL !== 1'b0 || PENABLE !== 1'b0 || req_ready !== '0 || rsp_valid !== '0 ||
          rsp_rdata !== '0 || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_drop: sel=%b en=%b rdy=%b rsp=%b rdata=%h err=%b want all 0",
                  PSEL, PENABLE, req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      @(negedge PCLK);
      PREADY = 1'b1;
      #1;
      n_tests++;
      if (rsp_valid !== '0 || PSEL !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_hold: rsp=%b sel=%b want 0 0", rsp_valid, PSEL);
      end
      PRESETn  = 1'b1;
      m_last   = N - 1;
      last_rd  = '0;
      last_err = 1'b0;
      do_transfer(1, $urandom, 1'b0, s, r);
      do_transfer(0, $urandom, 1'b0, s, r);
   endtask

   task automatic test_random();
      int s; logic [N-1:0] r;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) post_rand(i);
      if (!any_pending()) post_rand($urandom_range(0, N - 1));
      drive_reqs();
      for (int t = 0; t < 40; t++) begin
         do_transfer($urandom_range(0, 4), $urandom, 1'($urandom_range(0, 3) == 0), s, r);
         for (int i = 0; i < N; i++)
            if (!pending[i] && $urandom_range(0, 2) == 0) post_rand(i);
         if (!any_pending()) begin
            drive_reqs();
            repeat ($urandom_range(0, 2)) idle_cycle();
            post_rand($urandom_range(0, N - 1));
         end
         drive_reqs();
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         pending[i] = 1'b0; m_write[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0;
      end
      m_last = N - 1;
      last_rd = '0;
      last_err = 1'b0;
      PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
      drive_reqs();

      test_reset();
      test_single_read();
      test_write_wait();
      test_slverr();
      test_rotation();
      test_long_wait();
      test_reset_mid();
      test_random();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
